// File: rtl/avalon_body_fetch.sv
// avalon_body_fetch
// Avalon-MM read master that copies per-body render data (radius, X, Y, Z)
// from the body register file into a shadow buffer. Once every read of a pass
// has returned, the buffer is committed to the *_OUT registers in one cycle.
// The ball renderers therefore always see one consistent snapshot per frame.
//
// Ports:
//   CLK, RESET_N          clock, synchronous active-low reset
//   START                 one-cycle fetch request (frame start)
//   CLR_FLAGS             clears the sticky ERR and OVERRUN flags
//   AVL_*                 Avalon-MM master read port (one read outstanding)
//   RADIUS_OUT, POSX_OUT,
//   POSY_OUT, POSZ_OUT    committed snapshot; body b at [32(b-1)+:32]
//   BUSY                  fetch in progress
//   DONE                  one-cycle pulse when the snapshot is committed
//   ERR                   sticky; a read timed out
//   OVERRUN               sticky; START arrived while busy
module avalon_body_fetch #(
    parameter int N_BODIES  = 4,
    parameter int OFF_RAD   = 12,
    parameter int OFF_POS_X = 22,
    parameter int OFF_POS_Y = 32,
    parameter int OFF_POS_Z = 42,
    parameter int TIMEOUT   = 255
) (
    input  logic                    CLK,
    input  logic                    RESET_N,
    input  logic                    START,
    input  logic                    CLR_FLAGS,
    output logic                    AVL_READ,
    output logic                    AVL_CS,
    output logic [3:0]              AVL_BYTE_EN,
    output logic [7:0]              AVL_ADDR,
    input  logic                    AVL_WAITREQUEST,
    input  logic [31:0]             AVL_READDATA,
    input  logic                    AVL_READDATAVALID,
    output logic [32*N_BODIES-1:0]  RADIUS_OUT,
    output logic [32*N_BODIES-1:0]  POSX_OUT,
    output logic [32*N_BODIES-1:0]  POSY_OUT,
    output logic [32*N_BODIES-1:0]  POSZ_OUT,
    output logic                    BUSY,
    output logic                    DONE,
    output logic                    ERR,
    output logic                    OVERRUN
);

    localparam int N_READS = 4 * N_BODIES;
    localparam int IW      = $clog2(N_READS);
    localparam int TW      = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, COMMIT} state_t;

    state_t                    state, state_nxt;
    logic [IW-1:0]             idx;
    logic [TW-1:0]             tcnt;
    logic [N_READS-1:0][31:0]  shadow;
    logic                      last;
    logic                      timeout;
    logic [31:0]               base;
    logic [31:0]               body;
    logic [7:0]                addr_calc;

    // Read index layout: idx[1:0] selects the field, idx >> 2 the body (0-based).
    assign last    = (idx == IW'(N_READS - 1));
    assign timeout = (state == WAIT) && !AVL_READDATAVALID && (tcnt == TW'(TIMEOUT - 1));

    always_comb begin
        body = 32'(idx >> 2) + 32'd1;
        case (idx[1:0])
            2'd0:    base = 32'(OFF_RAD);
            2'd1:    base = 32'(OFF_POS_X);
            2'd2:    base = 32'(OFF_POS_Y);
            default: base = 32'(OFF_POS_Z);
        endcase
        addr_calc = 8'(base + body);
    end

    // State register
    always_ff @(posedge CLK) begin
        if (!RESET_N) state <= IDLE;
        else          state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:   if (START) state_nxt = REQ;
            REQ:    if (!AVL_WAITREQUEST) state_nxt = WAIT;
            WAIT: begin
                if (AVL_READDATAVALID) state_nxt = last ? COMMIT : REQ;
                else if (timeout)      state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs decoded from state; the address is only driven while requesting.
    always_comb begin
        AVL_READ    = (state == REQ);
        AVL_CS      = (state == REQ);
        AVL_BYTE_EN = 4'b1111;
        AVL_ADDR    = (state == REQ) ? addr_calc : 8'd0;
        BUSY        = (state != IDLE);
    end

    // Datapath: index, timeout counter, shadow buffer, committed snapshot, flags
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            idx        <= '0;
            tcnt       <= '0;
            shadow     <= '0;
            RADIUS_OUT <= '0;
            POSX_OUT   <= '0;
            POSY_OUT   <= '0;
            POSZ_OUT   <= '0;
            DONE       <= 1'b0;
            ERR        <= 1'b0;
            OVERRUN    <= 1'b0;
        end else begin
            // Registered so DONE lines up with the cycle the new snapshot appears.
            DONE <= (state == COMMIT);
            case (state)
                IDLE: if (START) idx <= '0;
                REQ:  if (!AVL_WAITREQUEST) tcnt <= '0;
                WAIT: begin
                    if (AVL_READDATAVALID) begin
                        shadow[idx] <= AVL_READDATA;
                        if (!last) idx <= idx + IW'(1);
                    end else if (timeout) begin
                        // Partial pass is thrown away; last snapshot stays visible.
                        shadow <= '0;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end
                COMMIT: begin
                    for (int b = 0; b < N_BODIES; b++) begin
                        RADIUS_OUT[32*b +: 32] <= shadow[4*b + 0];
                        POSX_OUT[32*b +: 32]   <= shadow[4*b + 1];
                        POSY_OUT[32*b +: 32]   <= shadow[4*b + 2];
                        POSZ_OUT[32*b +: 32]   <= shadow[4*b + 3];
                    end
                end
                default: ;
            endcase
            // Setting events take priority over a simultaneous clear.
            if (timeout)        ERR <= 1'b1;
            else if (CLR_FLAGS) ERR <= 1'b0;
            if (START && state != IDLE) OVERRUN <= 1'b1;
            else if (CLR_FLAGS)         OVERRUN <= 1'b0;
        end
    end

endmodule

// File: tb/tb_avalon_body_fetch.sv
module tb_avalon_body_fetch;

    logic         CLK = 1'b0;
    logic         RESET_N, START, CLR_FLAGS;
    logic         AVL_READ, AVL_CS, AVL_WAITREQUEST, AVL_READDATAVALID;
    logic [3:0]   AVL_BYTE_EN;
    logic [7:0]   AVL_ADDR;
    logic [31:0]  AVL_READDATA;
    logic [127:0] RADIUS_OUT, POSX_OUT, POSY_OUT, POSZ_OUT;
    logic         BUSY, DONE, ERR, OVERRUN;

    always #10 CLK = ~CLK;

    avalon_body_fetch dut (
        .CLK(CLK), .RESET_N(RESET_N), .START(START), .CLR_FLAGS(CLR_FLAGS),
        .AVL_READ(AVL_READ), .AVL_CS(AVL_CS), .AVL_BYTE_EN(AVL_BYTE_EN),
        .AVL_ADDR(AVL_ADDR), .AVL_WAITREQUEST(AVL_WAITREQUEST),
        .AVL_READDATA(AVL_READDATA), .AVL_READDATAVALID(AVL_READDATAVALID),
        .RADIUS_OUT(RADIUS_OUT), .POSX_OUT(POSX_OUT), .POSY_OUT(POSY_OUT),
        .POSZ_OUT(POSZ_OUT), .BUSY(BUSY), .DONE(DONE), .ERR(ERR), .OVERRUN(OVERRUN)
    );

    int checks = 0;
    int errors = 0;

    // Register-file slave model: zero waitstates (unless held), data one cycle after acceptance.
    logic [31:0] mem [256];
    logic        sl_valid = 1'b0;
    logic [31:0] sl_data = '0;
    logic        stray = 1'b0;
    logic        hold_en = 1'b0;
    int          hold_base = 0;
    int          hold_cnt = 0;
    int          acc_cnt = 0;
    int          cyc = 0;
    int          suppress_idx = -1;
    int          acc_addr[$];
    int          acc_edge[$];

    assign AVL_WAITREQUEST   = hold_en && AVL_READ && (AVL_ADDR == 8'd23) && (hold_cnt - hold_base < 5);
    assign AVL_READDATAVALID = sl_valid | stray;
    assign AVL_READDATA      = sl_data;

    always @(posedge CLK) begin
        cyc <= cyc + 1;
        if (AVL_WAITREQUEST) hold_cnt <= hold_cnt + 1;
        if (AVL_READ && !AVL_WAITREQUEST) begin
            acc_addr.push_back(int'(AVL_ADDR));
            acc_edge.push_back(cyc);
            sl_valid <= (acc_cnt != suppress_idx);
            sl_data  <= mem[AVL_ADDR];
            acc_cnt  <= acc_cnt + 1;
        end else begin
            sl_valid <= 1'b0;
        end
    end

    logic [127:0] exp_r, exp_x, exp_y, exp_z;

    task automatic tick();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    // Pulse START, return number of cycles until DONE is seen (START cycle = 1).
    task automatic run_fetch(output int n);
        START = 1'b1;
        tick();
        START = 1'b0;
        n = 1;
        while (!DONE && n < 2000) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        RESET_N = 1'b0; START = 1'b0; CLR_FLAGS = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = 32'hDEAD_0000 + 32'(i);
        for (int b = 1; b <= 4; b++) begin
            mem[12+b] = 32'(b * 10);
            mem[22+b] = 32'(100 + b);
            mem[32+b] = 32'(200 + b);
            mem[42+b] = 32'(300 + b);
            exp_r[32*(b-1) +: 32] = 32'(b * 10);
            exp_x[32*(b-1) +: 32] = 32'(100 + b);
            exp_y[32*(b-1) +: 32] = 32'(200 + b);
            exp_z[32*(b-1) +: 32] = 32'(300 + b);
        end
        @(negedge CLK);
        repeat (3) tick();
        checks++;
        if ({AVL_READ, AVL_CS, AVL_ADDR, BUSY, DONE, ERR, OVERRUN} !== 14'd0) begin
            errors++;
            $display("FAIL reset_ctrl: got %h expected 0", {AVL_READ, AVL_CS, AVL_ADDR, BUSY, DONE, ERR, OVERRUN});
        end
        checks++;
        if ({RADIUS_OUT, POSX_OUT, POSY_OUT, POSZ_OUT} !== 512'd0) begin
            errors++;
            $display("FAIL reset_outs: got nonzero snapshot expected 0");
        end
        checks++;
        if (AVL_BYTE_EN !== 4'b1111) begin
            errors++;
            $display("FAIL byte_en: got %b expected 1111", AVL_BYTE_EN);
        end
        RESET_N = 1'b1;
        tick();
        checks++;
        if (BUSY !== 1'b0 || AVL_READ !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: got busy=%b read=%b expected 0 0", BUSY, AVL_READ);
        end
    endtask

    task automatic test_basic();
        int n, base, exp_a;
        base = acc_cnt;
        run_fetch(n);
        checks++;
        if (n !== 34) begin
            errors++;
            $display("FAIL basic_latency: got %0d expected 34", n);
        end
        checks++;
        if (acc_cnt - base !== 16) begin
            errors++;
            $display("FAIL basic_reads: got %0d expected 16", acc_cnt - base);
        end
        for (int k = 0; k < 16; k++) begin
            exp_a = 12 + 10 * (k % 4) + (k / 4 + 1);
            checks++;
            if (acc_addr.size() <= base + k || acc_addr[base+k] !== exp_a) begin
                errors++;
                $display("FAIL basic_addr[%0d]: got %0d expected %0d", k,
                         (acc_addr.size() > base + k) ? acc_addr[base+k] : -1, exp_a);
            end
        end
        checks++;
        if (RADIUS_OUT[64 +: 32] !== 32'd30 || POSX_OUT[96 +: 32] !== 32'd104) begin
            errors++;
            $display("FAIL basic_r3_x4: got %0d %0d expected 30 104", RADIUS_OUT[64 +: 32], POSX_OUT[96 +: 32]);
        end
        checks++;
        if ({RADIUS_OUT, POSX_OUT, POSY_OUT, POSZ_OUT} !== {exp_r, exp_x, exp_y, exp_z}) begin
            errors++;
            $display("FAIL basic_snapshot: got r=%h expected r=%h", RADIUS_OUT, exp_r);
        end
        checks++;
        if (BUSY !== 1'b0) begin
            errors++;
            $display("FAIL busy_at_done: got %b expected 0", BUSY);
        end
        tick();
        checks++;
        if (DONE !== 1'b0) begin
            errors++;
            $display("FAIL done_pulse: got %b expected 0", DONE);
        end
    endtask

    task automatic test_waitreq();
        int n, base, stalls, n23;
        base = acc_cnt;
        hold_base = hold_cnt;
        hold_en = 1'b1;
        stalls = 0;
        START = 1'b1;
        tick();
        START = 1'b0;
        n = 1;
        while (!DONE && n < 2000) begin
            if (AVL_WAITREQUEST) begin
                stalls++;
                checks++;
                if (AVL_READ !== 1'b1 || AVL_CS !== 1'b1 || AVL_ADDR !== 8'd23) begin
                    errors++;
                    $display("FAIL stall_stable: got read=%b cs=%b addr=%0d expected 1 1 23", AVL_READ, AVL_CS, AVL_ADDR);
                end
            end
            tick();
            n++;
        end
        hold_en = 1'b0;
        checks++;
        if (stalls !== 5) begin
            errors++;
            $display("FAIL stall_count: got %0d expected 5", stalls);
        end
        checks++;
        if (n !== 39) begin
            errors++;
            $display("FAIL wait_latency: got %0d expected 39", n);
        end
        n23 = 0;
        for (int k = base; k < acc_addr.size(); k++) if (acc_addr[k] == 23) n23++;
        checks++;
        if (n23 !== 1 || acc_cnt - base !== 16) begin
            errors++;
            $display("FAIL wait_single_read: got %0d reads of 23, %0d total expected 1 16", n23, acc_cnt - base);
        end
        checks++;
        if ({RADIUS_OUT, POSX_OUT, POSY_OUT, POSZ_OUT} !== {exp_r, exp_x, exp_y, exp_z}) begin
            errors++;
            $display("FAIL wait_snapshot: got x=%h expected x=%h", POSX_OUT, exp_x);
        end
    endtask

    task automatic test_timeout();
        int n, base, dones, t_err, t_acc;
        base = acc_cnt;
        suppress_idx = base + 6;
        dones = 0;
        START = 1'b1;
        tick();
        START = 1'b0;
        n = 1;
        while (!ERR && n < 1000) begin
            if (DONE) dones++;
            tick();
            n++;
        end
        t_err = cyc;
        suppress_idx = -1;
        t_acc = (acc_edge.size() > base + 6) ? acc_edge[base+6] : -1000;
        checks++;
        if (ERR !== 1'b1 || t_err - t_acc !== 256) begin
            errors++;
            $display("FAIL timeout_cycles: got err=%b after %0d expected 1 after 256", ERR, t_err - t_acc);
        end
        checks++;
        if (dones !== 0 || DONE !== 1'b0 || BUSY !== 1'b0) begin
            errors++;
            $display("FAIL timeout_state: got dones=%0d busy=%b expected 0 0", dones, BUSY);
        end
        checks++;
        if (acc_cnt - base !== 7) begin
            errors++;
            $display("FAIL timeout_reads: got %0d expected 7", acc_cnt - base);
        end
        checks++;
        if ({RADIUS_OUT, POSX_OUT, POSY_OUT, POSZ_OUT} !== {exp_r, exp_x, exp_y, exp_z}) begin
            errors++;
            $display("FAIL timeout_keep: got r=%h expected r=%h", RADIUS_OUT, exp_r);
        end
        run_fetch(n);
        checks++;
        if (n !== 34 || ERR !== 1'b1) begin
            errors++;
            $display("FAIL after_timeout: got latency %0d err=%b expected 34 1", n, ERR);
        end
    endtask

    task automatic test_overrun();
        int n, base, busy_cnt;
        CLR_FLAGS = 1'b1;
        tick();
        CLR_FLAGS = 1'b0;
        checks++;
        if (ERR !== 1'b0 || OVERRUN !== 1'b0) begin
            errors++;
            $display("FAIL clr_err: got err=%b ovr=%b expected 0 0", ERR, OVERRUN);
        end
        // START mid-fetch
        base = acc_cnt;
        START = 1'b1;
        tick();
        n = 1;
        while (!DONE && n < 2000) begin
            START = (n == 10);
            tick();
            n++;
            if (n == 11) begin
                checks++;
                if (OVERRUN !== 1'b1 || BUSY !== 1'b1) begin
                    errors++;
                    $display("FAIL overrun_set: got ovr=%b busy=%b expected 1 1", OVERRUN, BUSY);
                end
            end
        end
        START = 1'b0;
        checks++;
        if (n !== 34) begin
            errors++;
            $display("FAIL overrun_latency: got %0d expected 34", n);
        end
        busy_cnt = 0;
        repeat (40) begin
            tick();
            if (BUSY || AVL_READ) busy_cnt++;
        end
        checks++;
        if (busy_cnt !== 0 || acc_cnt - base !== 16) begin
            errors++;
            $display("FAIL no_second_fetch: got busy=%0d reads=%0d expected 0 16", busy_cnt, acc_cnt - base);
        end
        CLR_FLAGS = 1'b1;
        tick();
        CLR_FLAGS = 1'b0;
        checks++;
        if (OVERRUN !== 1'b0) begin
            errors++;
            $display("FAIL clr_overrun: got %b expected 0", OVERRUN);
        end
        // START and CLR_FLAGS together while busy: set wins
        START = 1'b1;
        tick();
        START = 1'b1;
        CLR_FLAGS = 1'b1;
        tick();
        START = 1'b0;
        CLR_FLAGS = 1'b0;
        checks++;
        if (OVERRUN !== 1'b1) begin
            errors++;
            $display("FAIL set_wins: got %b expected 1", OVERRUN);
        end
        while (!DONE && n < 4000) begin tick(); n++; end
        CLR_FLAGS = 1'b1;
        tick();
        CLR_FLAGS = 1'b0;
        // START during the COMMIT cycle counts as busy
        START = 1'b1;
        tick();
        n = 1;
        while (!DONE && n < 2000) begin
            START = (n == 33);
            tick();
            n++;
        end
        START = 1'b0;
        checks++;
        if (n !== 34 || OVERRUN !== 1'b1 || BUSY !== 1'b0) begin
            errors++;
            $display("FAIL start_in_commit: got n=%0d ovr=%b busy=%b expected 34 1 0", n, OVERRUN, BUSY);
        end
        tick();
        checks++;
        if (BUSY !== 1'b0) begin
            errors++;
            $display("FAIL commit_start_ignored: got busy=%b expected 0", BUSY);
        end
        CLR_FLAGS = 1'b1;
        tick();
        CLR_FLAGS = 1'b0;
    endtask

    task automatic test_torn();
        int n, base, torn;
        logic changed;
        logic [127:0] exp_new;
        for (int b = 1; b <= 4; b++) mem[12+b] = 32'(1000 + 10 * b);
        exp_new = {32'd1040, 32'd1030, 32'd7777, 32'd1010};
        base = acc_cnt;
        changed = 1'b0;
        torn = 0;
        START = 1'b1;
        tick();
        START = 1'b0;
        n = 1;
        while (!DONE && n < 2000) begin
            if (!changed && acc_cnt - base == 4) begin
                mem[14] = 32'd7777;
                changed = 1'b1;
            end
            if (RADIUS_OUT !== exp_r) torn++;
            tick();
            n++;
        end
        checks++;
        if (torn !== 0 || !changed) begin
            errors++;
            $display("FAIL torn_before_done: got %0d changed cycles expected 0", torn);
        end
        checks++;
        if (n !== 34 || RADIUS_OUT !== exp_new) begin
            errors++;
            $display("FAIL torn_commit: got n=%0d r=%h expected 34 r=%h", n, RADIUS_OUT, exp_new);
        end
        exp_r = exp_new;
    endtask

    task automatic test_reset_mid();
        int n, base, bad;
        base = acc_cnt;
        START = 1'b1;
        tick();
        n = 1;
        while (acc_cnt - base < 10 && n < 2000) begin
            START = (n == 5);
            tick();
            n++;
        end
        START = 1'b0;
        checks++;
        if (OVERRUN !== 1'b1 || BUSY !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset: got ovr=%b busy=%b expected 1 1", OVERRUN, BUSY);
        end
        RESET_N = 1'b0;
        tick();
        checks++;
        if ({AVL_READ, AVL_CS, AVL_ADDR, BUSY, DONE, ERR, OVERRUN} !== 14'd0) begin
            errors++;
            $display("FAIL midreset_ctrl: got %h expected 0", {AVL_READ, AVL_CS, AVL_ADDR, BUSY, DONE, ERR, OVERRUN});
        end
        checks++;
        if ({RADIUS_OUT, POSX_OUT, POSY_OUT, POSZ_OUT} !== 512'd0) begin
            errors++;
            $display("FAIL midreset_outs: got r=%h expected 0", RADIUS_OUT);
        end
        RESET_N = 1'b1;
        stray = 1'b1;
        tick();
        stray = 1'b0;
        bad = 0;
        base = acc_cnt;
        repeat (5) begin
            if (BUSY || AVL_READ || DONE || RADIUS_OUT !== 128'd0) bad++;
            tick();
        end
        checks++;
        if (bad !== 0 || acc_cnt !== base) begin
            errors++;
            $display("FAIL stray_valid: got %0d bad cycles expected 0", bad);
        end
        run_fetch(n);
        checks++;
        if (n !== 34 || RADIUS_OUT !== exp_r || POSZ_OUT !== exp_z) begin
            errors++;
            $display("FAIL post_reset_fetch: got n=%0d r=%h expected 34 r=%h", n, RADIUS_OUT, exp_r);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_waitreq();
        test_timeout();
        test_overrun();
        test_torn();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/avalon_body_fetch.md
Name: avalon_body_fetch

Overview:
- Avalon-MM master that pulls per-body render data (radius, pos X/Y/Z) out of the body register-file slave once per frame.
- Reads into a shadow buffer and commits it atomically, so the ball renderers see one consistent snapshot per frame rather than values torn by in-flight FSM writes.
- Sits between the register-file slave and the ball pixel generators; a start pulse (VGA_VS rising edge, detected upstream) kicks off each fetch.

Parameters:
- N_BODIES, 4, bodies fetched per pass; body indices 1..N_BODIES.
- OFF_RAD, 12, word address of body 0 radius; body b radius at OFF_RAD+b.
- OFF_POS_X, 22, base word address of X positions.
- OFF_POS_Y, 32, base word address of Y positions.
- OFF_POS_Z, 42, base word address of Z positions.
- TIMEOUT, 255, maximum cycles from read acceptance to AVL_READDATAVALID.

Ports:
- CLK  in  1  system clock, 50 MHz.
- RESET_N  in  1  synchronous reset, active-low.
- START  in  1  one-cycle fetch request.
- CLR_FLAGS  in  1  clears ERR and OVERRUN.
- AVL_READ  out  1  Avalon-MM read request.
- AVL_CS  out  1  chip select; equals AVL_READ.
- AVL_BYTE_EN  out  4  always 4'b1111.
- AVL_ADDR  out  8  word address.
- AVL_WAITREQUEST  in  1  slave stall.
- AVL_READDATA  in  32  read data.
- AVL_READDATAVALID  in  1  read data valid.
- RADIUS_OUT  out  32*N_BODIES  committed radii; body b at [32(b-1)+:32].
- POSX_OUT, POSY_OUT, POSZ_OUT  out  32*N_BODIES each  committed positions, same packing.
- BUSY  out  1  high from START acceptance until return to IDLE.
- DONE  out  1  one-cycle pulse on commit.
- ERR  out  1  sticky; set on timeout.
- OVERRUN  out  1  sticky; set when START arrives while BUSY.

Behaviour:
- Reset (RESET_N low at CLK edge): all outputs 0, shadow buffer 0, state IDLE, counters 0. Reset mid-fetch aborts immediately; committed outputs are cleared, not preserved.
- Read order: body 1 rad, x, y, z; body 2 rad, x, y, z; …; 4*N_BODIES reads total.
- Address of field f for body b is OFF_f+b, truncated to 8 bits.
- One read outstanding at most.
- FSM states:
  - IDLE: on START, go to REQ with index 0; BUSY=1 from the next cycle.
  - REQ: AVL_READ=AVL_CS=1 with AVL_ADDR stable. While AVL_WAITREQUEST=1, hold the request. The read is accepted on the first cycle with WAITREQUEST=0; go to WAIT, drop AVL_READ next cycle, clear the timeout counter.
  - WAIT: AVL_READ=0. On AVL_READDATAVALID, write AVL_READDATA to the shadow slot for the current index. If the index is the last, go to COMMIT; otherwise increment the index and go to REQ. Without READDATAVALID, increment the timeout counter; on reaching TIMEOUT, set ERR, discard the shadow buffer, leave outputs unchanged, and go to IDLE.
  - COMMIT: copy the whole shadow buffer to the *_OUT registers in a single cycle, pulse DONE, go to IDLE. BUSY drops the same cycle DONE is high.
- READDATAVALID in IDLE, REQ or COMMIT is ignored.
- READDATAVALID in the same cycle a request is accepted does not complete that read.
- START while not IDLE: ignored, OVERRUN set. START in the COMMIT cycle counts as busy.
- CLR_FLAGS and a setting event in the same cycle: set wins.
- Minimum latency, with zero waitstates and READDATAVALID one cycle after acceptance: 1 + 4N*2 + 1 cycles from START to DONE, which is 34 for N=4.
- *_OUT change only in COMMIT or reset.

Test Plan:
- Slave preloaded with regfile[12+b]=b*10 and regfile[22+b]=100+b (b=1..4), zero waitstates, latency 1; START → address sequence 13,23,33,43,14,…,46, DONE at cycle 34, RADIUS_OUT body 3 = 30, POSX_OUT body 4 = 104.
- WAITREQUEST held high 5 cycles on address 23 → AVL_ADDR and AVL_READ stable for all 6 cycles, a single read issued, final data correct, DONE at cycle 39.
- READDATAVALID withheld on the 7th read with TIMEOUT=255 → ERR=1 after 255 wait cycles, no DONE, *_OUT keep the previous snapshot, BUSY=0, next START succeeds.
- START pulsed mid-fetch, then CLR_FLAGS → OVERRUN=1, fetch completes normally with no second fetch; CLR_FLAGS clears OVERRUN to 0.
- RESET_N low during the 10th read → next cycle all outputs 0, AVL_READ=0, state IDLE; a stray READDATAVALID after reset has no effect.
- Slave value changed between the body-1 and body-2 reads → *_OUT switch from old to new values only in the DONE cycle, never partially.
